// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding, default addresses and fetch-address check
package pc_sequencer_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

    // A fetch address is bad when misaligned or outside the instruction window.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - priority select of the next fetch PC
module pc_target_sel (
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] exc_vec,
    input  logic [31:0] epc,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] cur_pc,
    output logic [31:0] next_pc
);

    // Exception beats eret, eret beats branch redirect, otherwise sequential (wraps mod 2^32).
    always_comb begin
        next_pc = cur_pc + 32'd4;
        if (req) begin
            next_pc = exc_vec;
        end else if (eret) begin
            next_pc = epc;
        end else if (redirect) begin
            next_pc = redirect_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall hold, pending redirect and exception entry
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] f_pc,
    output logic        f_valid,
    output logic        f_adel,
    output logic        flush_fd
);

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic        pend_valid;
    logic [31:0] pend_target;

    logic        in_fetch;
    logic        in_hold;
    logic        present;
    logic        advance;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;

    assign in_fetch = (state == ST_FETCH);
    assign in_hold  = (state == ST_HOLD);

    assign f_adel   = addr_bad(pc_q, IMEM_LO, IMEM_HI);
    // A redirect from req/eret kills the F/D contents in the same cycle it is taken.
    assign flush_fd = (req | eret) & ~reset;

    // A bad address is treated as a word already in hand so the pipeline can trap on it.
    assign present  = in_hold | (in_fetch & (imem_ack | f_adel));
    assign advance  = ~flush_fd & present & ~stall;

    // A branch arriving in the advancing cycle is newer than any parked target.
    assign redirect        = br_taken | pend_valid;
    assign redirect_target = br_taken ? br_target : pend_target;

    assign imem_req  = in_fetch & ~f_adel;
    assign imem_addr = pc_q;
    assign f_pc      = pc_q;
    assign f_valid   = ~flush_fd & (state != ST_BOOT) &
                       ((in_fetch & imem_ack) | in_hold | f_adel);

    pc_target_sel u_target_sel (
        .req             (req),
        .eret            (eret),
        .exc_vec         (EXC_VEC),
        .epc             (epc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .cur_pc          (pc_q),
        .next_pc         (next_pc)
    );

    // PC register: loads on a flush redirect or on a normal advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (flush_fd || advance) begin
            pc_q <= next_pc;
        end
    end

    // Sequencer state: boot for one cycle, then fetch, parking in hold while stalled with a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else if (flush_fd) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: state <= (present && stall) ? ST_HOLD : ST_FETCH;
                ST_HOLD:  state <= stall ? ST_HOLD : ST_FETCH;
                default:  state <= ST_FETCH;
            endcase
        end
    end

    // One-entry pending redirect: parked while not advancing, consumed or discarded otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (flush_fd || advance) begin
            pend_valid  <= 1'b0;
        end else if (br_taken) begin
            pend_valid  <= 1'b1;
            pend_target <= br_target;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector table plus randomized reference-model check of pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC    = 32'h0000_4180;
    localparam logic [31:0] LO     = 32'h0000_3000;
    localparam logic [31:0] HI     = 32'h0000_6FFC;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        f_adel;
    logic        flush_fd;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .eret      (eret),
        .epc       (epc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_ack  (imem_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .f_pc      (f_pc),
        .f_valid   (f_valid),
        .f_adel    (f_adel),
        .flush_fd  (flush_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        eret;
        logic        br;
        logic        ack;
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        ireq;
        logic        adel;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic s, input logic r, input logic e, input logic b,
                                input logic a, input logic [31:0] t, input logic [31:0] ep,
                                input logic [31:0] pc, input logic v, input logic fl,
                                input logic ir, input logic ad);
        vec_t x;
        x.stall = s; x.req = r; x.eret = e; x.br = b; x.ack = a;
        x.tgt = t; x.epc = ep; x.pc = pc; x.valid = v; x.flush = fl;
        x.ireq = ir; x.adel = ad;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: fetch bookkeeping expressed as "where is the PC, is a word held, is a target parked".
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_holding;
    logic [31:0] m_pend[$];

    function automatic bit m_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < LO) || (a > HI);
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_booting = 1;
        m_holding = 0;
        m_pend.delete();
    endtask

    task automatic model_check(input string tag);
        bit       bad;
        bit       kill;
        bit       e_req;
        bit       e_valid;
        bad  = m_bad(m_pc);
        kill = req || eret;
        if (m_booting) begin
            e_req   = 0;
            e_valid = 0;
        end else if (m_holding) begin
            e_req   = 0;
            e_valid = !kill;
        end else begin
            e_req   = !bad;
            e_valid = !kill && (imem_ack || bad);
        end
        chk({tag, " f_pc"},      f_pc,      m_pc);
        chk({tag, " imem_addr"}, imem_addr, m_pc);
        chk({tag, " imem_req"},  {31'b0, imem_req}, {31'b0, e_req});
        chk({tag, " f_valid"},   {31'b0, f_valid},  {31'b0, e_valid});
        chk({tag, " f_adel"},    {31'b0, f_adel},   {31'b0, bad});
        chk({tag, " flush_fd"},  {31'b0, flush_fd}, {31'b0, kill});
    endtask

    task automatic model_edge();
        bit have_word;
        if (req || eret) begin
            m_pc      = req ? EXC : epc;
            m_booting = 0;
            m_holding = 0;
            m_pend.delete();
        end else if (m_booting) begin
            m_booting = 0;
            if (br_taken) m_pend = '{br_target};
        end else begin
            have_word = m_holding || imem_ack || m_bad(m_pc);
            if (have_word && !stall) begin
                if (br_taken)              m_pc = br_target;
                else if (m_pend.size() > 0) m_pc = m_pend[0];
                else                       m_pc = m_pc + 32'd4;
                m_pend.delete();
                m_holding = 0;
            end else begin
                if (have_word) m_holding = 1;
                if (br_taken) m_pend = '{br_target};
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom();
        else a = 32'h0000_3000 + ($urandom_range(0, 4095) * 4);
        return a;
    endfunction

    task automatic idle_inputs();
        stall = 0; req = 0; eret = 0; br_taken = 0; imem_ack = 0;
        epc = 32'h0; br_target = 32'h0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();

        // Directed sequence from reset release.
        tbl[0]  = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3000, 0,0,0,0);
        tbl[1]  = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3000, 1,0,1,0);
        tbl[2]  = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3004, 1,0,1,0);
        tbl[3]  = mk(1,0,0,1,1, 32'h0000_3100, 32'h0,         32'h0000_3008, 1,0,1,0);
        tbl[4]  = mk(1,0,0,0,1, 32'h0,         32'h0,         32'h0000_3008, 1,0,0,0);
        tbl[5]  = mk(1,0,0,0,1, 32'h0,         32'h0,         32'h0000_3008, 1,0,0,0);
        tbl[6]  = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3008, 1,0,0,0);
        tbl[7]  = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3100, 1,0,1,0);
        tbl[8]  = mk(1,0,0,1,1, 32'h0000_3200, 32'h0,         32'h0000_3104, 1,0,1,0);
        tbl[9]  = mk(1,1,0,0,0, 32'h0,         32'h0,         32'h0000_3104, 0,1,0,0);
        tbl[10] = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_4180, 1,0,1,0);
        tbl[11] = mk(0,0,1,1,1, 32'h0000_3300, 32'h0000_3020, 32'h0000_4184, 0,1,1,0);
        tbl[12] = mk(0,0,0,1,1, 32'h0000_3002, 32'h0,         32'h0000_3020, 1,0,1,0);
        tbl[13] = mk(0,0,0,1,0, 32'h0000_7000, 32'h0,         32'h0000_3002, 1,0,0,1);
        tbl[14] = mk(0,0,0,0,0, 32'h0,         32'h0,         32'h0000_7000, 1,0,0,1);
        tbl[15] = mk(0,1,1,0,0, 32'h0,         32'h0000_3020, 32'h0000_7004, 0,1,0,1);
        tbl[16] = mk(0,0,0,0,0, 32'h0,         32'h0,         32'h0000_4180, 0,0,1,0);
        tbl[17] = mk(0,0,0,1,0, 32'h0000_3040, 32'h0,         32'h0000_4180, 0,0,1,0);
        tbl[18] = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_4180, 1,0,1,0);
        tbl[19] = mk(0,0,0,0,1, 32'h0,         32'h0,         32'h0000_3040, 1,0,1,0);
        tbl[20] = mk(0,0,1,0,0, 32'h0,         32'hFFFF_FFFC, 32'h0000_3044, 0,1,1,0);
        tbl[21] = mk(0,0,0,0,0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1,0,0,1);
        tbl[22] = mk(0,0,0,0,0, 32'h0,         32'h0,         32'h0000_0000, 1,0,0,1);

        repeat (2) @(negedge clk);
        #1;
        chk("rst f_pc",     f_pc, RST_PC);
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst f_valid",  {31'b0, f_valid},  32'h0);
        chk("rst flush_fd", {31'b0, flush_fd}, 32'h0);

        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge clk);
            stall = tbl[i].stall; req = tbl[i].req; eret = tbl[i].eret;
            br_taken = tbl[i].br; imem_ack = tbl[i].ack;
            br_target = tbl[i].tgt; epc = tbl[i].epc;
            #1;
            chk($sformatf("vec%0d f_pc", i),      f_pc,      tbl[i].pc);
            chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].pc);
            chk($sformatf("vec%0d f_valid", i),   {31'b0, f_valid},  {31'b0, tbl[i].valid});
            chk($sformatf("vec%0d flush_fd", i),  {31'b0, flush_fd}, {31'b0, tbl[i].flush});
            chk($sformatf("vec%0d imem_req", i),  {31'b0, imem_req}, {31'b0, tbl[i].ireq});
            chk($sformatf("vec%0d f_adel", i),    {31'b0, f_adel},   {31'b0, tbl[i].adel});
        end

        // Reset asserted mid-cycle during an outstanding fetch, with req also high.
        @(negedge clk);
        idle_inputs();
        eret = 1; epc = 32'h0000_5000;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid pre imem_req", {31'b0, imem_req}, 32'h1);
        #2;
        reset = 1;
        req = 1;
        #1;
        chk("mid rst f_pc",     f_pc, RST_PC);
        chk("mid rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("mid rst f_valid",  {31'b0, f_valid},  32'h0);
        chk("mid rst flush_fd", {31'b0, flush_fd}, 32'h0);
        @(negedge clk);
        idle_inputs();
        imem_ack = 1;
        reset = 0;
        #1;
        chk("post rst boot imem_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        #1;
        chk("post rst first imem_req",  {31'b0, imem_req}, 32'h1);
        chk("post rst first imem_addr", imem_addr, RST_PC);

        // Randomized run against the reference model.
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            imem_ack  = ($urandom_range(0, 3) != 0);
            req       = ($urandom_range(0, 39) == 0);
            eret      = ($urandom_range(0, 39) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            br_target = rnd_addr();
            epc       = rnd_addr();
            #1;
            model_check($sformatf("rnd%0d", c));
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_3000, first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, 32'h0000_4180, exception handler entry.
REQ-003 SHALL have parameter IMEM_LO, 32'h0000_3000, lowest legal fetch address.
REQ-004 SHALL have parameter IMEM_HI, 32'h0000_6FFC, highest legal fetch address.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port stall  in  1  hazard unit holds F/D.
REQ-008 SHALL have port req  in  1  exception/interrupt taken this cycle.
REQ-009 SHALL have port eret  in  1  ERET taken this cycle.
REQ-010 SHALL have port epc  in  32  return address for eret.
REQ-011 SHALL have port br_taken  in  1  D-stage branch taken or jump.
REQ-012 SHALL have port br_target  in  32  D-stage redirect target.
REQ-013 SHALL have port imem_ack  in  1  instruction memory returns word for imem_addr.
REQ-014 SHALL have port imem_req  out  1  fetch request.
REQ-015 SHALL have port imem_addr  out  32  equals f_pc.
REQ-016 SHALL have port f_pc  out  32  current fetch PC.
REQ-017 SHALL have port f_valid  out  1  F-stage word valid for f_pc.
REQ-018 SHALL have port f_adel  out  1  fetch address error on f_pc.
REQ-019 SHALL have port flush_fd  out  1  kill F/D register contents.

Function
REQ-020 SHALL implement states BOOT, FETCH, HOLD; BOOT->FETCH unconditionally after one cycle.
REQ-021 SHALL in FETCH drive imem_req=1 (unless f_adel); on imem_ack with stall=0 advance f_pc, stay FETCH; on imem_ack with stall=1 go HOLD, f_pc unchanged.
REQ-022 SHALL in HOLD drive imem_req=0, f_valid=1; leave to FETCH with advance in the first cycle stall=0.
REQ-023 SHALL select next PC by priority req -> EXC_VEC, eret -> epc, pending/br_taken -> target, else f_pc+4 (mod 2^32).
REQ-024 SHALL apply req and eret in any state regardless of stall or imem_ack: load f_pc next edge, state FETCH, flush_fd=1 for exactly that cycle, pending redirect cleared.
REQ-025 SHALL, when br_taken arrives while not advancing (stall=1 or no ack), latch br_target into a one-entry pending register; later br_taken overwrites it; applied and cleared on the next advance.
REQ-026 SHALL sustain one fetch per cycle with zero-wait memory (ack same cycle as req).
REQ-027 SHALL assert f_valid combinationally as (FETCH && imem_ack) || HOLD || f_adel, forced 0 when flush_fd=1 or in BOOT.
REQ-028 SHALL assert f_adel when f_pc[1:0]!=0 or f_pc<IMEM_LO or f_pc>IMEM_HI; then imem_req=0, word treated as present, advance on stall=0 without ack.
REQ-029 SHALL wrap f_pc+4 from 32'hFFFF_FFFC to 0 with f_adel then asserted.
REQ-030 SHALL, when req and eret coincide, take req only.

Reset
REQ-031 SHALL on reset asynchronously set f_pc=RESET_PC, state BOOT, pending cleared, imem_req=0, f_valid=0, flush_fd=0.
REQ-032 SHALL discard an outstanding fetch if reset asserts mid-FETCH; first post-reset request is at RESET_PC.

Structure
REQ-033 SHALL take state encoding, RESET_PC/EXC_VEC/IMEM bounds defaults from a shared package.
REQ-034 SHALL place the priority target select in one combinational sub-module pc_target_sel.

Verification
REQ-035 SHALL cover reset release with ack held high -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles.
REQ-036 SHALL cover br_taken (target 0x3100) during stall=1 for 3 cycles -> f_pc held, after stall drops next f_pc=0x3100.
REQ-037 SHALL cover req during HOLD with pending branch -> flush_fd one cycle, f_pc=0x4180, pending discarded.
REQ-038 SHALL cover eret with epc=0x3020 simultaneous with br_taken -> f_pc=0x3020.
REQ-039 SHALL cover redirect to 0x3002 and to 0x7000 -> f_adel=1, imem_req=0, f_valid=1.
